tx_frame_fetch: RTL and testbench

Downstream consumer of the 128-bit Tx storage FIFO. Pops one stored frame at a time and unpacks it into CAN header and data fields. Presents the frame to the bit-stream processor (BSP) with a valid/ready handshake and holds it until the BSP reports success. On arbitration loss or error it re-presents the frame, up to a retry limit, then drops it.

---
 rtl/can_tx_pkg.sv | 22 ++
 rtl/can_frame_unpack.sv | 29 ++
 rtl/tx_frame_fetch.sv | 151 +++++++++++++++
 tb/tb_tx_frame_fetch.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/can_tx_pkg.sv
// can_tx_pkg: shared Tx frame word layout and fetch FSM encoding
package can_tx_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP     = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    ACTIVE  = 3'd4
  } tx_state_t;
  localparam int ID_STD_MSB    = 127;
  localparam int ID_STD_LSB    = 117;
  localparam int SRR_BIT       = 116;
  localparam int IDE_BIT       = 115;
  localparam int ID_EXT_MSB    = 114;
  localparam int ID_EXT_LSB    = 97;
  localparam int RTR_BIT       = 96;
  localparam int DLC_MSB       = 95;
  localparam int DLC_LSB       = 92;
  localparam int DATA_MSB      = 63;
  localparam int DATA_LSB      = 0;
  localparam int MAX_CAN_BYTES = 8;
endpackage

// File: rtl/can_frame_unpack.sv
// can_frame_unpack: splits a 128-bit Tx FIFO word into CAN header/data fields
//   i_word      stored frame word
//   o_id_std .. o_data  raw fields at their fixed bit positions
//   o_nbytes    payload bytes: 0 for remote frames, else DLC clamped to 8
module can_frame_unpack
  import can_tx_pkg::*;
(
  input  logic [127:0] i_word,
  output logic [10:0]  o_id_std,
  output logic         o_srr,
  output logic         o_ide,
  output logic [17:0]  o_id_ext,
  output logic         o_rtr,
  output logic [3:0]   o_dlc,
  output logic [63:0]  o_data,
  output logic [3:0]   o_nbytes
);
  logic w_unused_rsvd;
  assign o_id_std = i_word[ID_STD_MSB:ID_STD_LSB];
  assign o_srr    = i_word[SRR_BIT];
  assign o_ide    = i_word[IDE_BIT];
  assign o_id_ext = i_word[ID_EXT_MSB:ID_EXT_LSB];
  assign o_rtr    = i_word[RTR_BIT];
  assign o_dlc    = i_word[DLC_MSB:DLC_LSB];
  assign o_data   = i_word[DATA_MSB:DATA_LSB];
  // DLC 9..15 still means 8 bytes on the wire
  assign o_nbytes = o_rtr ? 4'd0 : (o_dlc > 4'(MAX_CAN_BYTES)) ? 4'(MAX_CAN_BYTES) : o_dlc;
  assign w_unused_rsvd = ^i_word[DLC_LSB-1:DATA_MSB+1];
endmodule

// File: rtl/tx_frame_fetch.sv
// tx_frame_fetch: pops one Tx FIFO frame at a time and presents it to the BSP with retry
//   sys_clk/IP2Can_reset  clock, async active-high reset
//   count1/load_data1     FIFO occupancy and write strobe (a write blocks a pop)
//   txfifo_op/deload_data1 FIFO read data (valid the cycle after a pop) and pop request
//   frame_valid/frame_ready handshake to the BSP; tx_* hold the unpacked frame
//   bsp_tx_done/bsp_tx_retry BSP outcome pulses, honoured only while ACTIVE
//   tx_busy (not IDLE), tx_drop (frame discarded after retries exhausted)
module tx_frame_fetch
  import can_tx_pkg::*;
#(
  parameter int MAX_RETRY = 8,
  parameter int RCW       = 4
)(
  input  logic         sys_clk,
  input  logic         IP2Can_reset,
  input  logic [5:0]   count1,
  input  logic         load_data1,
  input  logic [127:0] txfifo_op,
  output logic         deload_data1,
  output logic         frame_valid,
  input  logic         frame_ready,
  input  logic         bsp_tx_done,
  input  logic         bsp_tx_retry,
  output logic [10:0]  tx_id_std,
  output logic         tx_srr,
  output logic         tx_ide,
  output logic [17:0]  tx_id_ext,
  output logic         tx_rtr,
  output logic [3:0]   tx_dlc,
  output logic [63:0]  tx_data,
  output logic [3:0]   tx_nbytes,
  output logic         tx_busy,
  output logic         tx_drop
);
  localparam logic [RCW-1:0] RETRY_LIM = RCW'(MAX_RETRY);
  tx_state_t      r_state;
  logic [RCW-1:0] r_retry;
  logic           r_deload, r_valid, r_busy, r_drop;
  logic [10:0]    r_id_std;
  logic           r_srr, r_ide, r_rtr;
  logic [17:0]    r_id_ext;
  logic [3:0]     r_dlc, r_nbytes;
  logic [63:0]    r_data;
  logic [10:0]    w_id_std;
  logic           w_srr, w_ide, w_rtr;
  logic [17:0]    w_id_ext;
  logic [3:0]     w_dlc, w_nbytes;
  logic [63:0]    w_data;
  logic           w_retry_ok;
  logic [RCW-1:0] w_retry_inc;
  can_frame_unpack u_unpack (
    .i_word   (txfifo_op),
    .o_id_std (w_id_std),
    .o_srr    (w_srr),
    .o_ide    (w_ide),
    .o_id_ext (w_id_ext),
    .o_rtr    (w_rtr),
    .o_dlc    (w_dlc),
    .o_data   (w_data),
    .o_nbytes (w_nbytes)
  );
  assign w_retry_ok  = (MAX_RETRY == 0) || (r_retry < RETRY_LIM);
  // saturating increment so unlimited retry never wraps the counter
  assign w_retry_inc = r_retry + RCW'(r_retry != '1);
  always_ff @(posedge sys_clk or posedge IP2Can_reset) begin
    if (IP2Can_reset) begin
      r_state  <= IDLE;
      r_retry  <= '0;
      r_deload <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_drop   <= 1'b0;
      r_id_std <= '0;
      r_srr    <= 1'b0;
      r_ide    <= 1'b0;
      r_id_ext <= '0;
      r_rtr    <= 1'b0;
      r_dlc    <= '0;
      r_data   <= '0;
      r_nbytes <= '0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        IDLE:
          if (count1 != '0) begin
            r_state  <= POP;
            r_deload <= 1'b1;
            r_busy   <= 1'b1;
          end
        // a concurrent FIFO write swallows the pop, so keep asking
        POP:
          if (!load_data1) begin
            r_state  <= WAIT;
            r_deload <= 1'b0;
          end
        WAIT: begin
          r_id_std <= w_id_std;
          r_srr    <= w_srr;
          r_ide    <= w_ide;
          r_id_ext <= w_id_ext;
          r_rtr    <= w_rtr;
          r_dlc    <= w_dlc;
          r_data   <= w_data;
          r_nbytes <= w_nbytes;
          r_retry  <= '0;
          r_state  <= PRESENT;
          r_valid  <= 1'b1;
        end
        PRESENT:
          if (frame_ready) begin
            r_state <= ACTIVE;
            r_valid <= 1'b0;
          end
        // done outranks a simultaneous retry
        ACTIVE:
          if (bsp_tx_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (bsp_tx_retry) begin
            if (w_retry_ok) begin
              r_retry <= w_retry_inc;
              r_state <= PRESENT;
              r_valid <= 1'b1;
            end else begin
              r_drop  <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        default: begin
          r_state  <= IDLE;
          r_deload <= 1'b0;
          r_valid  <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end
  assign deload_data1 = r_deload;
  assign frame_valid  = r_valid;
  assign tx_busy      = r_busy;
  assign tx_drop      = r_drop;
  assign tx_id_std    = r_id_std;
  assign tx_srr       = r_srr;
  assign tx_ide       = r_ide;
  assign tx_id_ext    = r_id_ext;
  assign tx_rtr       = r_rtr;
  assign tx_dlc       = r_dlc;
  assign tx_data      = r_data;
  assign tx_nbytes    = r_nbytes;
endmodule

// File: tb/tb_tx_frame_fetch.sv
// tb_tx_frame_fetch: scoreboard bench with FIFO model, random BSP and reference field model
module tb_tx_frame_fetch;
  localparam int MAXR = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] count1 = '0;
  logic load_data1 = 1'b0;
  logic [127:0] txfifo_op = '0, wr_word = '0, pw;
  logic frame_ready = 1'b0, done = 1'b0, retry = 1'b0;
  logic deload_data1, frame_valid, tx_srr, tx_ide, tx_rtr, tx_busy, tx_drop;
  logic [10:0] tx_id_std;
  logic [17:0] tx_id_ext;
  logic [3:0] tx_dlc, tx_nbytes;
  logic [63:0] tx_data;
  logic [103:0] dut_f;
  logic [107:0] all_out;
  logic [127:0] fifo_q[$];
  logic [103:0] exp_q[$];
  bit bsp_en = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  tx_frame_fetch #(.MAX_RETRY(MAXR), .RCW(4)) dut (
    .sys_clk(clk), .IP2Can_reset(rst), .count1(count1), .load_data1(load_data1),
    .txfifo_op(txfifo_op), .deload_data1(deload_data1), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .bsp_tx_done(done), .bsp_tx_retry(retry),
    .tx_id_std(tx_id_std), .tx_srr(tx_srr), .tx_ide(tx_ide), .tx_id_ext(tx_id_ext),
    .tx_rtr(tx_rtr), .tx_dlc(tx_dlc), .tx_data(tx_data), .tx_nbytes(tx_nbytes),
    .tx_busy(tx_busy), .tx_drop(tx_drop)
  );
  assign dut_f   = {tx_id_std, tx_srr, tx_ide, tx_id_ext, tx_rtr, tx_dlc, tx_data, tx_nbytes};
  assign all_out = {deload_data1, frame_valid, tx_busy, tx_drop, dut_f};
  function automatic logic [103:0] model(input logic [127:0] w);
    logic [3:0] dlc, nb;
    dlc = w[95:92];
    nb = w[96] ? 4'd0 : (dlc > 4'd8 ? 4'd8 : dlc);
    return {w[127:97], w[96], dlc, w[63:0], nb};
  endfunction
  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  // FIFO model: a write wins over a pop; popped data appears the following cycle
  initial forever begin
    @(posedge clk);
    if (load_data1) fifo_q.push_back(wr_word);
    else if (deload_data1) begin
      if (fifo_q.size() == 0) chk("pop_from_empty", 1, 0);
      else begin
        pw = fifo_q.pop_front();
        txfifo_op <= pw;
        exp_q.push_back(model(pw));
      end
    end
    count1 <= 6'(fifo_q.size());
  end
  // monitor: compares each presentation and tracks done/retry/drop outcomes
  initial begin
    bit active = 0, exp_drop = 0;
    int retries = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0; exp_drop = 0; retries = 0;
      end else begin
        chk("tx_drop", tx_drop, exp_drop);
        exp_drop = 0;
        if (deload_data1) chk("pop_while_outstanding", exp_q.size() != 0, 0);
        if (frame_valid && frame_ready) begin
          if (exp_q.size() == 0) chk("present_without_pop", 1, 0);
          else chk("fields", dut_f, exp_q[0]);
          active = 1;
        end else if (active && done) begin
          void'(exp_q.pop_front());
          active = 0; retries = 0;
        end else if (active && retry) begin
          active = 0;
          if (retries < MAXR) retries++;
          else begin
            exp_drop = 1; retries = 0;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end
  // BSP driver: scripted outcomes first (done, 3 retries -> drop, done+retry), then random
  initial begin
    int mode = 0, dly = 0, si = 0, c, r;
    int script[5] = '{0, 1, 1, 1, 2};
    forever begin
      @(posedge clk); #1;
      done = 0; retry = 0; frame_ready = 0;
      if (!bsp_en || rst) begin
        mode = 0; dly = 0;
      end else if (mode == 0) begin
        if (frame_valid && dly == 0) begin
          frame_ready = 1; mode = 1; dly = $urandom_range(0, 3);
        end else begin
          if (frame_valid) dly--;
          if ($urandom_range(0, 7) == 0) begin
            retry = 1; done = 1'($urandom_range(0, 1));
          end
        end
      end else if (dly > 0) dly--;
      else begin
        r = $urandom_range(0, 19);
        c = (si < 5) ? script[si] : (r < 9) ? 1 : (r < 11) ? 2 : 0;
        done = (c != 1); retry = (c != 0);
        si++; mode = 0; dly = $urandom_range(0, 3);
      end
    end
  end
  initial begin
    logic [127:0] w;
    int n, c0;
    w = '0; w[127:117] = 11'h555; w[95:92] = 4'd5; w[63:0] = 64'h1122334455667788;
    fifo_q.push_back(w);
    w[95:92] = 4'd12; w[91:64] = 28'hFFFFFFF;
    fifo_q.push_back(w);
    w[96] = 1'b1; w[95:92] = 4'd4;
    fifo_q.push_back(w);
    repeat (5) begin
      @(negedge clk);
      chk("reset_outputs", all_out, 0);
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk); chk("deload_before_pop", deload_data1, 0);
    @(negedge clk); chk("deload_pop", deload_data1, 1);
    @(negedge clk); chk("deload_one_cycle", deload_data1, 0); chk("valid_in_wait", frame_valid, 0);
    @(negedge clk); chk("valid_after_pop", frame_valid, 1);
    chk("w1_id_std", tx_id_std, 11'h555);
    chk("w1_nbytes", tx_nbytes, 5);
    chk("w1_data", tx_data, 64'h1122334455667788);
    bsp_en = 1;
    n = 0;
    @(posedge clk); #1;
    while (!deload_data1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("second_pop_seen", deload_data1, 1);
    c0 = int'(count1);
    load_data1 = 1;
    for (int i = 0; i < 3; i++) begin
      wr_word = rand_word();
      @(posedge clk); #1;
      chk("deload_held", deload_data1, 1);
    end
    load_data1 = 0;
    @(posedge clk); #1;
    chk("deload_released", deload_data1, 0);
    chk("count_net", count1, 128'(c0 + 2));
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      wr_word = rand_word();
      load_data1 = (fifo_q.size() < 40) && ($urandom_range(0, 11) == 0);
    end
    load_data1 = 0;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || tx_busy) && n < 8000) begin
      @(negedge clk); n++;
    end
    chk("drain_in_time", n < 8000, 1);
    chk("drain_idle", tx_busy, 0);
    bsp_en = 0;
    @(posedge clk); #1;
    wr_word = rand_word(); load_data1 = 1;
    @(posedge clk); #1 load_data1 = 0;
    n = 0;
    @(negedge clk);
    while (!frame_valid && n < 50) begin
      @(negedge clk); n++;
    end
    chk("present_before_reset", frame_valid, 1);
    #2 rst = 1;
    #1 chk("async_reset_outputs", all_out, 0);
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("reset_hold_outputs", all_out, 0);
    end
    @(posedge clk); #1 rst = 0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_reset", {tx_busy, tx_drop, frame_valid}, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
